// File: rtl/spi_reg_bridge_pkg.sv
// Shared types and field positions for the SPI register bridge.
package spi_reg_bridge_pkg;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_HDR       = 4'd1,
      S_RD_STROBE = 4'd2,
      S_RD_CAPT   = 4'd3,
      S_RD_SHIFT  = 4'd4,
      S_WDATA     = 4'd5,
      S_WR_STROBE = 4'd6,
      S_DONE      = 4'd7
   } state_t;

   localparam int HDR_BITS          = 32;
   localparam int DATA_BITS         = 32;
   localparam int ADDR_CTRL_SEL_BIT = 0;
   localparam int ADDR_CTRL_RD_BIT  = 1;
   localparam int HDR_ADDR_MSB      = 31;
   localparam int HDR_ADDR_LSB      = 16;
   localparam int HDR_RW_BIT        = 15;

   function automatic logic [31:0] mk_addr_ctrl(input logic [15:0] addr, input logic rd);
      logic [31:0] ac;
      ac                    = '0;
      ac[31:16]             = addr;
      ac[ADDR_CTRL_RD_BIT]  = rd;
      ac[ADDR_CTRL_SEL_BIT] = 1'b1;
      return ac;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input with rise/fall pulse detect.
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_r <= {SYNC_STAGES{RST_VAL}};
         prev   <= RST_VAL;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], d};
         prev   <= sync_r[SYNC_STAGES-1];
      end
   end

   assign q    = sync_r[SYNC_STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI-slave (mode 0) to register-bus bridge: 32-bit header + 32-bit data frames.
// Define SPI_REG_BRIDGE_PARITY_EN to require odd parity over the header.
module spi_reg_bridge
   import spi_reg_bridge_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int ERR_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             spi_sclk,
   input  logic             spi_cs_n,
   input  logic             spi_mosi,
   output logic             spi_miso,
   output logic [31:0]      addr_ctrl,
   output logic [31:0]      reg_wr_data,
   input  logic [31:0]      reg_rd_data,
   output logic             busy,
   output logic [ERR_W-1:0] err_count,
   output logic [7:0]       debug
);

   state_t                 state, state_nx;
   logic                   sclk_s, sclk_rise, sclk_fall;
   logic                   cs_s, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   mosi_s;
   logic [HDR_BITS-2:0]    sr;
   logic [HDR_BITS-1:0]    rx_word;
   logic [15:0]            hdr_addr;
   logic [DATA_BITS-1:0]   miso_sr;
   logic [4:0]             bit_cnt;
   logic                   rd_armed, err_inc, par_ok;
   logic                   shift_in, shift_out, last_hdr, last_data;
   logic                   unused_ok;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
      .clk(clk), .reset(reset), .d(spi_sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall));

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
      .clk(clk), .reset(reset), .d(spi_cs_n), .q(cs_s), .rise(cs_rise), .fall(cs_fall));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) mosi_sync <= '0;
      else       mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
   end

   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign unused_ok = &{1'b0, sclk_s, cs_rise};
   assign rx_word   = {sr, mosi_s};
   assign last_hdr  = (bit_cnt == 5'(HDR_BITS - 1));
   assign last_data = (bit_cnt == 5'(DATA_BITS - 1));
   assign shift_in  = ((state == S_HDR) || (state == S_WDATA)) && sclk_rise;
   // The fall right after the last header bit precedes the host's first data sample,
   // so read shifting only starts once a data-phase rising edge has been seen.
   assign shift_out = (state == S_RD_SHIFT) && sclk_fall && rd_armed;

`ifdef SPI_REG_BRIDGE_PARITY_EN
   assign par_ok = ^rx_word;
`else
   assign par_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // A sampled sclk edge takes priority over a cs_n release seen in the same cycle.
   always_comb begin
      state_nx = state;
      err_inc  = 1'b0;
      case (state)
         S_IDLE:      if (cs_fall) state_nx = S_HDR;
         S_HDR: begin
            if (sclk_rise) begin
               if (last_hdr) begin
                  if (!par_ok) begin
                     state_nx = S_DONE;
                     err_inc  = 1'b1;
                  end else begin
                     state_nx = rx_word[HDR_RW_BIT] ? S_RD_STROBE : S_WDATA;
                  end
               end
            end else if (cs_s) begin
               state_nx = S_IDLE;
               err_inc  = 1'b1;
            end
         end
         S_WDATA: begin
            if (sclk_rise) begin
               if (last_data) state_nx = S_WR_STROBE;
            end else if (cs_s) begin
               state_nx = S_IDLE;
               err_inc  = 1'b1;
            end
         end
         S_RD_STROBE: state_nx = S_RD_CAPT;
         S_RD_CAPT:   state_nx = S_RD_SHIFT;
         S_RD_SHIFT: begin
            if (shift_out) begin
               if (last_data) state_nx = S_DONE;
            end else if (cs_s) begin
               state_nx = S_IDLE;
               err_inc  = 1'b1;
            end
         end
         S_WR_STROBE: state_nx = S_DONE;
         S_DONE:      if (cs_s) state_nx = S_IDLE;
         default:     state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr          <= '0;
         hdr_addr    <= '0;
         bit_cnt     <= '0;
         rd_armed    <= 1'b0;
         miso_sr     <= '0;
         addr_ctrl   <= '0;
         reg_wr_data <= '0;
         err_count   <= '0;
      end else begin
         if (state_nx != state)        bit_cnt <= '0;
         else if (shift_in | shift_out) bit_cnt <= bit_cnt + 5'd1;

         if (shift_in) sr <= rx_word[HDR_BITS-2:0];
         if ((state == S_HDR) && sclk_rise && last_hdr)
            hdr_addr <= rx_word[HDR_ADDR_MSB:HDR_ADDR_LSB];

         if (state != S_RD_SHIFT) rd_armed <= 1'b0;
         else if (sclk_rise)      rd_armed <= 1'b1;

         if (state == S_RD_CAPT) miso_sr <= reg_rd_data;
         else if (shift_out)     miso_sr <= {miso_sr[DATA_BITS-2:0], 1'b0};

         // Address/R-W bits persist after the strobe; only select is dropped.
         if (state_nx == S_RD_STROBE)
            addr_ctrl <= mk_addr_ctrl(rx_word[HDR_ADDR_MSB:HDR_ADDR_LSB], 1'b1);
         else if (state_nx == S_WR_STROBE)
            addr_ctrl <= mk_addr_ctrl(hdr_addr, 1'b0);
         else
            addr_ctrl[ADDR_CTRL_SEL_BIT] <= 1'b0;

         if (state_nx == S_WR_STROBE) reg_wr_data <= rx_word;

         if (err_inc && !(&err_count)) err_count <= err_count + ERR_W'(1);
      end
   end

   assign spi_miso = (state == S_RD_SHIFT) & miso_sr[DATA_BITS-1];
   assign busy     = (state != S_IDLE);
   assign debug    = {state, bit_cnt[3:0]};

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: a host model drives SPI frames and a
// scoreboard of expected register-bus strobes is matched against observed ones.
module tb_spi_reg_bridge;
   import spi_reg_bridge_pkg::*;

   localparam int HALF = 8;

   logic        clk = 1'b0, reset = 1'b1;
   logic        spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
   logic        spi_miso, busy;
   logic [31:0] addr_ctrl, reg_wr_data, reg_rd_data;
   logic [7:0]  err_count, debug;

   spi_reg_bridge #(.SYNC_STAGES(2), .ERR_W(8)) dut (
      .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .addr_ctrl(addr_ctrl),
      .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data), .busy(busy),
      .err_count(err_count), .debug(debug));

   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] ac; logic [31:0] wd; } strobe_t;

   strobe_t     exp_q[$], obs_q[$];
   logic [31:0] rd_exp_q[$];
   int          n_chk = 0, n_fail = 0;
   int          exp_err = 0;
   logic [31:0] exp_wd = 32'h0;
   logic        busy_mid;

   function automatic logic [31:0] rd_model(input logic [15:0] a);
      return (a == 16'h0002) ? 32'hDEADBEEF : {a, ~a};
   endfunction

   // Register block model: registered read data, valid the cycle after select.
   always_ff @(posedge clk)
      reg_rd_data <= (addr_ctrl[0] && addr_ctrl[1]) ? rd_model(addr_ctrl[31:16]) : 32'h0;

   function automatic logic [31:0] mk_hdr(input logic [15:0] a, input logic rw, input logic odd);
      logic [31:0] h;
      h    = {a, rw, 15'h0};
      h[0] = odd ? ~^h[31:1] : ^h[31:1];
      return h;
   endfunction

   function automatic logic [31:0] mk_ac(input logic [15:0] a, input logic rd);
      return {a, 14'h0, rd, 1'b1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (addr_ctrl[0]) obs_q.push_back({addr_ctrl, reg_wr_data});
   endtask

   task automatic spi_bits(input logic [63:0] f, input int n, output logic [31:0] rx);
      rx = '0;
      for (int i = 0; i < n; i++) begin
         spi_mosi = f[63-i];
         repeat (HALF) tick();
         spi_sclk = 1'b1;
         if (i >= 32) rx = {rx[30:0], spi_miso};
         repeat (HALF) tick();
         spi_sclk = 1'b0;
      end
   endtask

   task automatic spi_frame(input logic [63:0] f, input int n, output logic [31:0] rx);
      spi_cs_n = 1'b0;
      repeat (HALF) tick();
      busy_mid = busy;
      spi_bits(f, n, rx);
      repeat (HALF) tick();
      spi_cs_n = 1'b1;
      repeat (2 * HALF) tick();
   endtask

   task automatic push_wr(input logic [15:0] a, input logic [31:0] d);
      exp_wd = d;
      exp_q.push_back({mk_ac(a, 1'b0), d});
   endtask

   task automatic push_rd(input logic [15:0] a);
      exp_q.push_back({mk_ac(a, 1'b1), exp_wd});
      rd_exp_q.push_back(rd_model(a));
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      n_chk++; if (addr_ctrl !== 32'h0)   begin n_fail++; $display("FAIL reset addr_ctrl: got %h want 0", addr_ctrl); end
      n_chk++; if (reg_wr_data !== 32'h0) begin n_fail++; $display("FAIL reset reg_wr_data: got %h want 0", reg_wr_data); end
      n_chk++; if (spi_miso !== 1'b0)     begin n_fail++; $display("FAIL reset miso: got %b want 0", spi_miso); end
      n_chk++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
      n_chk++; if (err_count !== 8'h0)    begin n_fail++; $display("FAIL reset err_count: got %0d want 0", err_count); end
      n_chk++; if (debug !== 8'h0)        begin n_fail++; $display("FAIL reset debug: got %h want 0", debug); end
      reset = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_write();
      logic [31:0] rx;
      strobe_t o, e;
      push_wr(16'h0002, 32'hDEADBEEF);
      spi_frame({mk_hdr(16'h0002, 1'b0, 1'b1), 32'hDEADBEEF}, 64, rx);
      n_chk++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL write strobe_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_chk++; if (o !== e) begin n_fail++; $display("FAIL write strobe: got %h want %h", o, e); end
      end
      obs_q.delete(); exp_q.delete();
      n_chk++; if (busy_mid !== 1'b1)         begin n_fail++; $display("FAIL write busy_mid: got %b want 1", busy_mid); end
      n_chk++; if (busy !== 1'b0)             begin n_fail++; $display("FAIL write busy_after: got %b want 0", busy); end
      n_chk++; if (reg_wr_data !== exp_wd)    begin n_fail++; $display("FAIL write hold_wr_data: got %h want %h", reg_wr_data, exp_wd); end
      n_chk++; if (err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL write err_count: got %0d want %0d", err_count, exp_err); end
   endtask

   task automatic test_read();
      logic [31:0] rx, r;
      strobe_t o, e;
      logic [15:0] addrs [2];
      addrs[0] = 16'h0002; addrs[1] = 16'h1234;
      for (int k = 0; k < 2; k++) begin
         push_rd(addrs[k]);
         spi_frame({mk_hdr(addrs[k], 1'b1, 1'b1), 32'h0}, 64, rx);
         r = rd_exp_q.pop_front();
         n_chk++; if (rx !== r) begin n_fail++; $display("FAIL read miso_word: got %h want %h", rx, r); end
      end
      n_chk++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL read strobe_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_chk++; if (o !== e) begin n_fail++; $display("FAIL read strobe: got %h want %h", o, e); end
      end
      obs_q.delete(); exp_q.delete();
      n_chk++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL read miso_idle: got %b want 0", spi_miso); end
   endtask

   task automatic test_abort();
      logic [31:0] rx;
      strobe_t o, e;
      // write cut after 20 data bits, header cut after 10 bits, read cut mid-shift
      spi_frame({mk_hdr(16'h0040, 1'b0, 1'b1), 32'h12345678}, 52, rx);
      exp_err++;
      n_chk++; if (err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL abort wdata_err: got %0d want %0d", err_count, exp_err); end
      n_chk++; if (reg_wr_data !== exp_wd)    begin n_fail++; $display("FAIL abort wr_data_kept: got %h want %h", reg_wr_data, exp_wd); end
      spi_frame({mk_hdr(16'h0041, 1'b0, 1'b1), 32'h0}, 10, rx);
      exp_err++;
      n_chk++; if (err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL abort hdr_err: got %0d want %0d", err_count, exp_err); end
      push_rd(16'h0042);
      void'(rd_exp_q.pop_front());
      spi_frame({mk_hdr(16'h0042, 1'b1, 1'b1), 32'h0}, 40, rx);
      exp_err++;
      n_chk++; if (err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL abort rd_err: got %0d want %0d", err_count, exp_err); end
      n_chk++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL abort strobe_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_chk++; if (o !== e) begin n_fail++; $display("FAIL abort strobe: got %h want %h", o, e); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_parity();
      logic [31:0] rx, r;
      strobe_t o, e;
`ifdef SPI_REG_BRIDGE_PARITY_EN
      r = 32'h0;
      exp_err++;
`else
      push_rd(16'h00A5);
      r = rd_exp_q.pop_front();
`endif
      spi_frame({mk_hdr(16'h00A5, 1'b1, 1'b0), 32'h0}, 64, rx);
      n_chk++; if (rx !== r) begin n_fail++; $display("FAIL parity bad_hdr_miso: got %h want %h", rx, r); end
      n_chk++; if (err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL parity err_count: got %0d want %0d", err_count, exp_err); end
      push_wr(16'h00A6, 32'hCAFE0001);
      spi_frame({mk_hdr(16'h00A6, 1'b0, 1'b1), 32'hCAFE0001}, 64, rx);
      n_chk++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL parity strobe_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_chk++; if (o !== e) begin n_fail++; $display("FAIL parity strobe: got %h want %h", o, e); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [31:0] rx, r, d;
      logic [15:0] a;
      strobe_t o, e;
      for (int k = 0; k < 4; k++) begin
         a = 16'($urandom_range(0, 16'hFFFF));
         d = $urandom;
         push_wr(a, d);
         spi_frame({mk_hdr(a, 1'b0, 1'b1), d}, 64, rx);
      end
      a = 16'h8001;
      push_rd(a);
      spi_frame({mk_hdr(a, 1'b1, 1'b1), 32'h0}, 64, rx);
      r = rd_exp_q.pop_front();
      n_chk++; if (rx !== r) begin n_fail++; $display("FAIL b2b miso_word: got %h want %h", rx, r); end
      n_chk++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b strobe_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_chk++; if (o !== e) begin n_fail++; $display("FAIL b2b strobe: got %h want %h", o, e); end
      end
      obs_q.delete(); exp_q.delete();
      n_chk++; if (err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL b2b err_count: got %0d want %0d", err_count, exp_err); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rx;
      logic [7:0]  dbg_exp;
      strobe_t o, e;
      // read of 0x0055 returns 0x0055FFAA; after 11 data falls miso shows bit 20 (=1)
      push_rd(16'h0055);
      void'(rd_exp_q.pop_front());
      spi_cs_n = 1'b0;
      repeat (HALF) tick();
      spi_bits({mk_hdr(16'h0055, 1'b1, 1'b1), 32'h0}, 43, rx);
      repeat (HALF) tick();
      dbg_exp = {S_RD_SHIFT, 4'd11};
      n_chk++; if (spi_miso !== 1'b1)  begin n_fail++; $display("FAIL rstmid miso_pre: got %b want 1", spi_miso); end
      n_chk++; if (debug !== dbg_exp)  begin n_fail++; $display("FAIL rstmid debug_pre: got %h want %h", debug, dbg_exp); end
      reset = 1'b1;
      #1;
      n_chk++; if (spi_miso !== 1'b0)     begin n_fail++; $display("FAIL rstmid miso: got %b want 0", spi_miso); end
      n_chk++; if (addr_ctrl !== 32'h0)   begin n_fail++; $display("FAIL rstmid addr_ctrl: got %h want 0", addr_ctrl); end
      n_chk++; if (reg_wr_data !== 32'h0) begin n_fail++; $display("FAIL rstmid reg_wr_data: got %h want 0", reg_wr_data); end
      n_chk++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL rstmid busy: got %b want 0", busy); end
      n_chk++; if (debug !== 8'h0)        begin n_fail++; $display("FAIL rstmid debug: got %h want 0", debug); end
      spi_cs_n = 1'b1;
      spi_sclk = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      exp_wd = 32'h0; exp_err = 0;
      repeat (4) tick();
      push_wr(16'h0003, 32'h0BADF00D);
      spi_frame({mk_hdr(16'h0003, 1'b0, 1'b1), 32'h0BADF00D}, 64, rx);
      n_chk++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid strobe_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_chk++; if (o !== e) begin n_fail++; $display("FAIL rstmid strobe: got %h want %h", o, e); end
      end
      obs_q.delete(); exp_q.delete();
      n_chk++; if (err_count !== 8'h0) begin n_fail++; $display("FAIL rstmid err_count: got %0d want 0", err_count); end
   endtask

   task automatic test_saturate();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (2) tick();
      for (int k = 1; k <= 300; k++) begin
         spi_cs_n = 1'b0;
         repeat (6) tick();
         spi_cs_n = 1'b1;
         repeat (6) tick();
         if (k == 100 || k == 255 || k == 300) begin
            exp_err = (k > 255) ? 255 : k;
            n_chk++; if (err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL saturate err_count@%0d: got %0d want %0d", k, err_count, exp_err); end
         end
      end
      n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL saturate strobes: got %0d want 0", obs_q.size()); end
      obs_q.delete();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_abort();
      test_parity();
      test_back_to_back();
      test_reset_mid();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
